// File: rtl/br_recovery_ctrl_pkg.sv
// Shared types and helpers for branch misprediction recovery.
package br_recovery_ctrl_pkg;

    localparam int unsigned ADDR_WIDTH_DEF = 32;
    localparam int unsigned ROB_DEPTH_DEF  = 32;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        WAIT_ROB,
        REDIRECT
    } RecovState_t;

    // Distance of a ROB id from the head.
    // The subtraction wraps naturally in ROB bits, and the smaller result is older.
    // Callers pass zero-extended ids and truncate the result to the ROB width.
    function automatic logic [31:0] rob_age(input logic [31:0] id,
                                            input logic [31:0] head,
                                            input int unsigned depth);
        return (id - head) & (depth - 32'd1);
    endfunction

endpackage

// File: rtl/br_recovery_ctrl_if.sv
// Bus between the branch lanes, ROB, fetch and the recovery controller.
interface br_recovery_ctrl_if #(
    parameter int unsigned ADDR      = 32,
    parameter int unsigned ROB_DEPTH = 32,
    parameter int unsigned NUM_BR    = 2
);
    localparam int unsigned ROB = $clog2(ROB_DEPTH);

    logic [NUM_BR-1:0]      br_valid;
    logic [NUM_BR-1:0]      br_miss_;
    logic [NUM_BR*ROB-1:0]  br_rob_id;
    logic [NUM_BR*ADDR-1:0] br_target;
    logic [ROB-1:0]         rob_head;
    logic                   rob_flush_done;
    logic                   fetch_ready;
    logic                   flush;
    logic [ROB-1:0]         flush_rob_id;
    logic                   redirect_valid;
    logic [ADDR-1:0]        redirect_addr;
    logic                   recovering;

    modport master (
        output br_valid, br_miss_, br_rob_id, br_target, rob_head,
               rob_flush_done, fetch_ready,
        input  flush, flush_rob_id, redirect_valid, redirect_addr, recovering
    );

    modport slave (
        input  br_valid, br_miss_, br_rob_id, br_target, rob_head,
               rob_flush_done, fetch_ready,
        output flush, flush_rob_id, redirect_valid, redirect_addr, recovering
    );

endinterface

// File: rtl/br_recovery_ctrl_oldest_sel.sv
// Combinational N-way oldest-miss selector. On equal age the lowest lane wins.
module br_oldest_sel
    import br_recovery_ctrl_pkg::*;
#(
    parameter int unsigned NUM_BR    = 2,
    parameter int unsigned ROB_DEPTH = ROB_DEPTH_DEF,
    parameter int unsigned ADDR      = ADDR_WIDTH_DEF,
    localparam int unsigned ROB      = $clog2(ROB_DEPTH)
) (
    input  logic [NUM_BR-1:0]      miss,
    input  logic [NUM_BR*ROB-1:0]  rob_id,
    input  logic [NUM_BR*ADDR-1:0] target,
    input  logic [ROB-1:0]         rob_head,
    output logic                   sel_valid,
    output logic [ROB-1:0]         sel_rob_id,
    output logic [ADDR-1:0]        sel_target,
    output logic [ROB-1:0]         sel_age
);

    logic [ROB-1:0] lane_age;

    // Scan lanes in index order; a strict compare keeps the lowest index on ties.
    always_comb begin
        sel_valid  = 1'b0;
        sel_rob_id = '0;
        sel_target = '0;
        sel_age    = '0;
        lane_age   = '0;
        for (int unsigned i = 0; i < NUM_BR; i++) begin
            lane_age = ROB'(rob_age(32'(rob_id[i*ROB +: ROB]), 32'(rob_head), ROB_DEPTH));
            if (miss[i] && (!sel_valid || lane_age < sel_age)) begin
                sel_valid  = 1'b1;
                sel_rob_id = rob_id[i*ROB +: ROB];
                sel_target = target[i*ADDR +: ADDR];
                sel_age    = lane_age;
            end
        end
    end

endmodule

// File: rtl/br_recovery_ctrl.sv
// Picks the oldest branch misprediction and sequences the recovery:
// ROB flush, wait for the flush to complete, then redirect fetch.
module br_recovery_ctrl
    import br_recovery_ctrl_pkg::*;
#(
    parameter int unsigned ADDR      = ADDR_WIDTH_DEF,
    parameter int unsigned ROB_DEPTH = ROB_DEPTH_DEF,
    parameter int unsigned NUM_BR    = 2,
    localparam int unsigned ROB      = $clog2(ROB_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    br_recovery_ctrl_if.slave bus
);

    RecovState_t     state, state_n;
    logic [ROB-1:0]  cap_id, cap_id_n;
    logic [ADDR-1:0] cap_target, cap_target_n;
    logic [ROB-1:0]  cap_age;

    logic [NUM_BR-1:0] lane_miss;
    logic              sel_valid;
    logic [ROB-1:0]    sel_rob_id;
    logic [ROB-1:0]    sel_age;
    logic [ADDR-1:0]   sel_target;

    assign lane_miss = bus.br_valid & ~bus.br_miss_;

    // The age of the capture moves as the ROB head retires instructions.
    assign cap_age = ROB'(rob_age(32'(cap_id), 32'(bus.rob_head), ROB_DEPTH));

    br_oldest_sel #(
        .NUM_BR   (NUM_BR),
        .ROB_DEPTH(ROB_DEPTH),
        .ADDR     (ADDR)
    ) u_sel (
        .miss      (lane_miss),
        .rob_id    (bus.br_rob_id),
        .target    (bus.br_target),
        .rob_head  (bus.rob_head),
        .sel_valid (sel_valid),
        .sel_rob_id(sel_rob_id),
        .sel_target(sel_target),
        .sel_age   (sel_age)
    );

    // State and capture registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cap_id     <= '0;
            cap_target <= '0;
        end else begin
            state      <= state_n;
            cap_id     <= cap_id_n;
            cap_target <= cap_target_n;
        end
    end

    // Next state and capture update. A strictly older miss during FLUSH or
    // WAIT_ROB restarts the flush and takes priority over rob_flush_done.
    always_comb begin
        logic take;
        state_n      = state;
        cap_id_n     = cap_id;
        cap_target_n = cap_target;
        take         = 1'b0;
        unique case (state)
            IDLE: begin
                take = sel_valid;
            end
            FLUSH, WAIT_ROB: begin
                if (sel_valid && sel_age < cap_age) begin
                    take = 1'b1;
                end else if (state == FLUSH) begin
                    state_n = WAIT_ROB;
                end else if (bus.rob_flush_done) begin
                    state_n = REDIRECT;
                end
            end
            REDIRECT: begin
                if (bus.fetch_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (take) begin
            state_n      = FLUSH;
            cap_id_n     = sel_rob_id;
            cap_target_n = sel_target;
        end
    end

    assign bus.flush          = (state == FLUSH);
    assign bus.flush_rob_id   = (state == FLUSH) ? cap_id : '0;
    assign bus.redirect_valid = (state == REDIRECT);
    assign bus.redirect_addr  = (state == REDIRECT) ? cap_target : '0;
    assign bus.recovering     = (state != IDLE);

endmodule

// File: doc/br_recovery_ctrl.md
Name: br_recovery_ctrl

Overview:
Collects branch/jump misprediction reports from NUM_BR branch-resolve ALU lanes and selects the oldest one by ROB age. It then sequences the recovery: ROB flush, wait for flush completion, fetch redirect. It sits between the ALU branch-compare outputs and the ROB/fetch front end, and is the only source of pipeline flush and redirect.

Parameters:
ADDR, `AddrWidth, instruction address width
ROB_DEPTH, `RobDepth, ROB entries; must be a power of two
NUM_BR, 2, number of branch-resolving ALU lanes
ROB, $clog2(ROB_DEPTH), ROB id width (derived, not overridable)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
br_valid  in  NUM_BR  lane i holds a resolved branch/jump this cycle
br_miss_  in  NUM_BR  active-low; lane i mispredicted (pred_miss_ AND jump_miss_); ignored unless br_valid[i]
br_rob_id  in  NUM_BR*ROB  ROB id of lane i, lane i at [i*ROB +: ROB]
br_target  in  NUM_BR*ADDR  correct next PC of lane i, lane i at [i*ADDR +: ADDR]
rob_head  in  ROB  ROB id of the oldest in-flight instruction
rob_flush_done  in  1  ROB has discarded all entries younger than flush_rob_id
fetch_ready  in  1  fetch accepts a redirect this cycle
flush  out  1  one-cycle pulse: flush everything younger than flush_rob_id
flush_rob_id  out  ROB  ROB id of the mispredicted instruction (it is kept)
redirect_valid  out  1  redirect request to fetch
redirect_addr  out  ADDR  redirect target
recovering  out  1  high in every state except IDLE; front end stalls issue

Behaviour:
- Reset (synchronous, active-high): state=IDLE. flush=0, flush_rob_id=0, redirect_valid=0, redirect_addr=0, recovering=0. Any capture in progress is abandoned; no flush or redirect is emitted after reset.
- Lane i is a miss when br_valid[i] && !br_miss_[i].
- Age: age_i = (br_rob_id_i - rob_head) mod ROB_DEPTH, computed in ROB bits with natural wrap. The smaller age is older.
- Selection: the oldest missing lane wins. On an equal rob id, the lower lane index wins.
- Captured entry: cap_id and cap_target registers. cap_age is recomputed each cycle against the current rob_head.
- States:
  - IDLE: when any miss is present, capture the winner, go to FLUSH. There is no flush in the capture cycle, so latency is 1 cycle from miss to flush.
  - FLUSH: flush=1 for exactly this cycle; flush_rob_id=cap_id. Next state WAIT_ROB.
  - WAIT_ROB: hold until rob_flush_done=1, then go to REDIRECT. rob_flush_done is ignored in all other states.
  - REDIRECT: redirect_valid=1, redirect_addr=cap_target, held stable until fetch_ready=1. On the handshake cycle the next state is IDLE and redirect_valid drops the following cycle.
- Older miss during recovery:
  - In FLUSH or WAIT_ROB, a new miss with age < cap_age (the cap_age test is strict) replaces the capture and the state returns to FLUSH, which re-issues flush.
  - A miss with age >= cap_age is dropped, because it is a younger instruction that is already being flushed.
  - In REDIRECT, all miss inputs are ignored; lanes are squashed by then.
- Simultaneous events:
  - A replacing miss in the same cycle as rob_flush_done: the replacement wins, go to FLUSH.
  - A miss in the IDLE cycle right after a REDIRECT handshake is handled normally.
- recovering is high combinationally in FLUSH, WAIT_ROB and REDIRECT, and is registered with the state.
- All outputs are driven from registers or the state decode; there is no combinational path from br_* to flush or redirect_*.

Decomposition:
- Shared package (exe.svh/branch.svh): the RecovState_t enum (IDLE, FLUSH, WAIT_ROB, REDIRECT) and the age-compare helper function rob_age(id, head).
- Sub-module br_oldest_sel: a combinational NUM_BR-way oldest-miss selector with a lowest-index tie-break. It outputs sel_valid, sel_rob_id, sel_target and sel_age, and is reused by the ROB commit logic.

Test Plan:
- Single miss, ROB_DEPTH=32: rob_head=3, lane0 miss with rob_id=7, target=0x100. Required: flush=1 one cycle later with flush_rob_id=7. After rob_flush_done, redirect_valid=1 with redirect_addr=0x100 until fetch_ready, then state returns to IDLE.
- Dual miss with wrap: rob_head=30, lane0 rob_id=1 (age 3), lane1 rob_id=31 (age 1). Required: flush_rob_id=31 and lane1's target is redirected.
- Older miss in WAIT_ROB: capture rob_id=10 with head=0, then lane1 misses with rob_id=5. Required: a second flush pulse with flush_rob_id=5 and the target of id 5 is redirected. A later miss with rob_id=12 is ignored.
- Back-pressure: fetch_ready held at 0 for 4 cycles in REDIRECT. Required: redirect_valid and redirect_addr are stable, recovering=1, and miss inputs have no effect.
- Reset mid-recovery: assert reset during WAIT_ROB. Required: the next cycle has all outputs 0 and IDLE, and no redirect is issued afterwards.
- Tie and invalid lanes:
  - Both lanes report rob_id=4: lane0's target is used.
  - br_valid=0 with br_miss_=0: no flush.
